// File: rtl/soc_pio_pkg.sv
// Shared definitions for the soc PIO slaves: register offsets and STATUS bit positions.
package soc_pio_pkg;

  // Register word offsets on the 3-bit slave address.
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  // STATUS register bit positions.
  localparam int STATUS_PHASE_BIT     = 0;
  localparam int STATUS_PERIOD_NZ_BIT = 1;

endpackage

// File: rtl/soc_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
interface soc_led_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/soc_pio_blink_timer.sv
// Blink timebase: counts half-periods of `period` cycles and toggles `phase`
// at the end of each. A zero period parks the timer with phase high.
module soc_pio_blink_timer #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    restart,
  output logic                    phase
);

  logic [PERIOD_WIDTH-1:0] cnt_reg;
  logic [PERIOD_WIDTH-1:0] cnt_next;
  logic                    phase_reg;
  logic                    phase_next;
  logic                    terminal;

  assign terminal = (cnt_reg == period - PERIOD_WIDTH'(1));

  // Next count/phase; a restart (PERIOD write) beats a terminal-count toggle.
  always_comb begin
    cnt_next   = cnt_reg + PERIOD_WIDTH'(1);
    phase_next = phase_reg;
    if (restart || (period == '0)) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (terminal) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end
  end

  // Counter and phase state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/soc_led_pio.sv
// Avalon-MM output PIO for board LEDs: DATA register with atomic set/clear,
// per-bit blink enables and a hardware blink timebase.
module soc_led_pio
  import soc_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    PERIOD_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET   = '0,
  parameter int                    PERIOD_RESET = 12500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  soc_led_pio_if.slave          avs,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                    wr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [PERIOD_WIDTH-1:0] wperiod;
  logic                    period_wr;
  logic                    phase;
  logic                    unused_wdata;

  logic [DATA_WIDTH-1:0]   data_reg;
  logic [DATA_WIDTH-1:0]   blink_reg;
  logic [PERIOD_WIDTH-1:0] period_reg;
  logic [31:0]             rd_next;
  logic [DATA_WIDTH-1:0]   out_next;

  assign wr        = avs.chipselect & ~avs.write_n;
  assign wdata     = avs.writedata[DATA_WIDTH-1:0];
  assign wperiod   = avs.writedata[PERIOD_WIDTH-1:0];
  assign period_wr = wr && (avs.address == ADDR_PERIOD);

  // Upper writedata bits are don't-care for every register.
  assign unused_wdata = ^avs.writedata;

  // Register file: one register updated per write cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= DATA_RESET;
      blink_reg  <= '0;
      period_reg <= PERIOD_WIDTH'(PERIOD_RESET);
    end else if (wr) begin
      case (avs.address)
        ADDR_DATA:   data_reg   <= wdata;
        ADDR_BLINK:  blink_reg  <= wdata;
        ADDR_PERIOD: period_reg <= wperiod;
        ADDR_OUTSET: data_reg   <= data_reg | wdata;
        ADDR_OUTCLR: data_reg   <= data_reg & ~wdata;
        default:     ;
      endcase
    end
  end

  soc_pio_blink_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_reg),
    .restart (period_wr),
    .phase   (phase)
  );

  // Read mux over current register values; write-only and reserved words read 0.
  always_comb begin
    rd_next = '0;
    case (avs.address)
      ADDR_DATA:   rd_next = 32'(data_reg);
      ADDR_BLINK:  rd_next = 32'(blink_reg);
      ADDR_PERIOD: rd_next = 32'(period_reg);
      ADDR_STATUS: begin
        rd_next[STATUS_PHASE_BIT]     = phase;
        rd_next[STATUS_PERIOD_NZ_BIT] = |period_reg;
      end
      default:     ;
    endcase
  end

  // Blinking bits are forced low during the low phase.
  always_comb begin
    out_next = data_reg & ~(blink_reg & {DATA_WIDTH{~phase}});
  end

  // Registered read data and pin outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
      out_port     <= DATA_RESET;
    end else begin
      avs.readdata <= rd_next;
      out_port     <= out_next;
    end
  end

endmodule

// File: tb/tb_soc_led_pio.sv
// Directed testbench for soc_led_pio: register access, set/clear, blink timing, async reset.
module tb_soc_led_pio;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;
  int         checks   = 0;
  int         failures = 0;

  soc_led_pio_if bus ();

  soc_led_pio #(
    .DATA_WIDTH   (8),
    .PERIOD_WIDTH (24),
    .DATA_RESET   (8'h00),
    .PERIOD_RESET (12500000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write: asserted from one falling edge to the next, so it lands on the rising edge between.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    $display("WR addr=%0d data=0x%08h", a, d);
  endtask

  // Read: address presented, readdata sampled one clock later.
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    $display("RD addr=%0d data=0x%08h exp=0x%08h", a, bus.readdata, exp);
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    reset_n        = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'h00);
    check("rst_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    rd(3'd3, 32'h3, "rst_status");
    rd(3'd2, 32'd12500000, "rst_period");
    rd(3'd1, 32'h0, "rst_blink");

    // DATA write; upper writedata bits ignored; read-during-write returns old value
    rd(3'd0, 32'h0, "data_before");
    wr(3'd0, 32'hFFFFFFA5);
    check("rdw_old_value", bus.readdata, 32'h0);
    check("out_lag_edge_k", 32'(out_port), 32'h00);
    @(negedge clk);
    check("data_new_value", bus.readdata, 32'hA5);
    check("out_edge_k1", 32'(out_port), 32'hA5);

    // Atomic set / clear
    wr(3'd4, 32'h0A);
    rd(3'd0, 32'hAF, "outset_data");
    wr(3'd5, 32'h81);
    rd(3'd0, 32'h2E, "outclr_data");
    rd(3'd4, 32'h0, "outset_reads0");
    rd(3'd5, 32'h0, "outclr_reads0");
    wr(3'd6, 32'h55);
    rd(3'd6, 32'h0, "rsvd6_reads0");
    wr(3'd3, 32'hFF);
    rd(3'd3, 32'h3, "status_wr_ignored");
    rd(3'd0, 32'h2E, "data_after_misc");

    // Blink: half-period 4, low nibble blinking
    wr(3'd1, 32'h0F);
    wr(3'd0, 32'hFF);
    wr(3'd2, 32'h4);
    bus.address = 3'd3;
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      check($sformatf("blink4_out_%0d", j), 32'(out_port),
            ((((j - 1) / 4) % 2) == 0) ? 32'hFF : 32'hF0);
      check($sformatf("blink4_status_%0d", j), bus.readdata,
            ((((j - 1) / 4) % 2) == 0) ? 32'h3 : 32'h2);
    end
    $display("BLINK period=4 21 cycles observed");

    // Period rewrite while phase low mid-count restarts high
    wr(3'd2, 32'h3);
    bus.address = 3'd3;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check($sformatf("blink3_out_%0d", j), 32'(out_port),
            ((((j - 1) / 3) % 2) == 0) ? 32'hFF : 32'hF0);
      check($sformatf("blink3_status_%0d", j), bus.readdata,
            ((((j - 1) / 3) % 2) == 0) ? 32'h3 : 32'h2);
    end
    $display("BLINK period=3 9 cycles observed");

    // Period zero disables blinking
    wr(3'd2, 32'h0);
    bus.address = 3'd3;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check($sformatf("p0_out_%0d", j), 32'(out_port), 32'hFF);
      check($sformatf("p0_status_%0d", j), bus.readdata, 32'h1);
    end
    $display("BLINK period=0 steady");

    // Asynchronous reset in the middle of a low phase
    wr(3'd2, 32'h4);
    bus.address = 3'd0;
    repeat (6) @(negedge clk);
    check("pre_rst_out", 32'(out_port), 32'hF0);
    check("pre_rst_readdata", bus.readdata, 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_port), 32'h00);
    check("async_rst_readdata", bus.readdata, 32'h0);
    $display("ASYNC reset asserted between edges");
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd2, 32'd12500000, "post_rst_period");
    rd(3'd3, 32'h3, "post_rst_status");
    rd(3'd1, 32'h0, "post_rst_blink");
    rd(3'd0, 32'h0, "post_rst_data");
    check("post_rst_out", 32'(out_port), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
